joypad_events: RTL

Downstream consumer of the NES controller bridge. Samples each `joypad`/`joypad_valid` report and turns button changes into press/release events with a sequence stamp. Buffers the events in a small FIFO and exposes current state, events and status to the RISC-V core as four memory-mapped 32-bit registers, with an optional interrupt.

---
 rtl/joypad_events_pkg.sv | 22 ++
 rtl/joypad_event_fifo.sv | 54 +++++
 rtl/joypad_events.sv | 111 +++++++++++
 3 files changed

// File: rtl/joypad_events_pkg.sv
// Shared definitions for the joypad event block: register map, STATUS bit
// positions and the layout of a queued event entry.
package joypad_events_pkg;

    typedef enum logic [1:0] {
        JP_REG_STATE  = 2'd0,
        JP_REG_EVENT  = 2'd1,
        JP_REG_STATUS = 2'd2,
        JP_REG_SEQ    = 2'd3
    } jp_reg_e;

    localparam int JP_ST_OVF   = 8;
    localparam int JP_ST_IRQEN = 9;

    // Entry field offsets: pressed [7:0], released [15:8], seq [31:16].
    typedef struct packed {
        logic [15:0] seq;
        logic [7:0]  released;
        logic [7:0]  pressed;
    } jp_entry_t;

endpackage

// File: rtl/joypad_event_fifo.sv
// 32-bit synchronous FIFO with wrap-bit pointers; dout always shows the head.
module joypad_event_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk_half,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [31:0]                din,
    output logic [31:0]                dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign dout  = mem[rd_ptr_q[AW-1:0]];

    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_half or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_half) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/joypad_events.sv
// Turns joypad samples into stamped press/release events and exposes them,
// with live state and status, as four memory-mapped 32-bit registers.
module joypad_events
    import joypad_events_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk_half,
    input  logic        rst_n,
    input  logic [7:0]  joypad,
    input  logic        joypad_valid,
    input  logic [1:0]  bus_addr,
    input  logic        bus_re,
    input  logic        bus_we,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]  cur_q, cur_d;
    logic [15:0] seq_q, seq_d;
    logic        ovf_q, ovf_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] rdata_q, rdata_d;

    logic [7:0]  pressed, released;
    jp_entry_t   entry;
    logic        push, pop, wr_status, ovf_set, ovf_clr;
    logic [31:0] fifo_dout;
    logic [CW-1:0] fifo_count;
    logic        fifo_full, fifo_empty;
    jp_reg_e     reg_sel;
    logic        unused_wdata;

    assign reg_sel  = jp_reg_e'(bus_addr);
    assign pressed  = joypad & ~cur_q;
    assign released = ~joypad & cur_q;
    assign entry    = '{seq: seq_q, released: released, pressed: pressed};
    assign push     = joypad_valid & (|(pressed | released));
    assign pop      = bus_re & (reg_sel == JP_REG_EVENT);
    assign wr_status = bus_we & (reg_sel == JP_REG_STATUS);

    // An overflowing push wins over a same-cycle write-clear of ovf.
    assign ovf_set = push & fifo_full & ~pop;
    assign ovf_clr = wr_status & bus_wdata[JP_ST_OVF];

    assign unused_wdata = ^{bus_wdata[31:10], bus_wdata[7:0]};

    joypad_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_half (clk_half),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .din      (entry),
        .dout     (fifo_dout),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // NOTE: next-state logic is combinational with every output defaulted first, so no latches.
    always_comb begin
        cur_d    = cur_q;
        seq_d    = seq_q;
        irq_en_d = irq_en_q;
        rdata_d  = rdata_q;
        ovf_d    = ovf_set | (ovf_q & ~ovf_clr);

        if (joypad_valid) begin
            cur_d = joypad;
            seq_d = seq_q + 16'd1;
        end
        if (wr_status) irq_en_d = bus_wdata[JP_ST_IRQEN];

        if (bus_re) begin
            unique case (reg_sel)
                JP_REG_STATE:  rdata_d = {24'b0, cur_q};
                JP_REG_EVENT:  rdata_d = fifo_empty ? 32'b0 : fifo_dout;
                JP_REG_STATUS: begin
                    rdata_d = '0;
                    rdata_d[6:0]         = 7'(fifo_count);
                    rdata_d[JP_ST_OVF]   = ovf_q;
                    rdata_d[JP_ST_IRQEN] = irq_en_q;
                end
                JP_REG_SEQ:    rdata_d = {16'b0, seq_q};
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_half or negedge rst_n) begin
        if (!rst_n) begin
            cur_q    <= '0;
            seq_q    <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            cur_q    <= cur_d;
            seq_q    <= seq_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign irq       = irq_en_q & (~fifo_empty | ovf_q);

endmodule
